// File: rtl/stopwatch_bcd.sv
// stopwatch_bcd: BCD stopwatch M:SS.CC (0:00.00 .. 9:59.99) driven by a
// 1 ms tic strobe, with start/stop, lap-hold and clear command pulses.
//
// Ports:
//   clk         system clock, rising edge
//   rst         asynchronous active-high reset
//   tic         timebase strobe, one pulse per prescaler step
//   start_stop  pulse, toggles run/pause (IDLE -> RUN on first press)
//   lap         pulse, freezes / releases the displayed time
//   clear       pulse, returns to IDLE with all time state zeroed
//   d_cs0       displayed hundredths units
//   d_cs1       displayed tenths
//   d_s0        displayed seconds units
//   d_s1        displayed seconds tens (0-5)
//   d_m0        displayed minutes (0-9)
//   running     high while in RUN
//   hold        high while the display is frozen
//   wrap        one-cycle pulse on 9:59.99 -> 0:00.00
module stopwatch_bcd #(
   parameter int unsigned TICKS_PER_UNIT = 10
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tic,
   input  logic       start_stop,
   input  logic       lap,
   input  logic       clear,
   output logic [3:0] d_cs0,
   output logic [3:0] d_cs1,
   output logic [3:0] d_s0,
   output logic [3:0] d_s1,
   output logic [3:0] d_m0,
   output logic       running,
   output logic       hold,
   output logic       wrap
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      PAUSED = 2'd2
   } state_t;

   localparam logic [7:0] PRE_MAX = 8'(TICKS_PER_UNIT - 1);

   state_t state;
   state_t state_nx;

   logic [7:0] pre;

   // live time
   logic [3:0] cs0;
   logic [3:0] cs1;
   logic [3:0] s0;
   logic [3:0] s1;
   logic [3:0] m0;

   // lap-held time
   logic [3:0] h_cs0;
   logic [3:0] h_cs1;
   logic [3:0] h_s0;
   logic [3:0] h_s1;
   logic [3:0] h_m0;

   logic       count_en;
   logic       unit_en;
   logic [5:0] cy;
   logic       lap_act;

   logic [3:0] cs0_nx;
   logic [3:0] cs1_nx;
   logic [3:0] s0_nx;
   logic [3:0] s1_nx;
   logic [3:0] m0_nx;

   // Advance a digit; anything at or above its top value rolls to zero,
   // so a corrupted digit heals instead of leaving BCD range.
   function automatic logic [3:0] bcd_inc(
      input logic [3:0] d,
      input logic [3:0] top
   );
      return (d >= top) ? 4'd0 : d + 4'd1;
   endfunction

   // ---------------- FSM ----------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
      if (clear) begin
         state_nx = IDLE;
      end else if (start_stop) begin
         unique case (state)
            IDLE:    state_nx = RUN;
            RUN:     state_nx = PAUSED;
            PAUSED:  state_nx = RUN;
            default: state_nx = IDLE;
         endcase
      end
   end

   // tic is judged against the current state, so a tic arriving with the
   // start press is not counted but one arriving with the stop press is.
   assign count_en = tic && (state == RUN) && !clear;
   assign unit_en  = count_en && (pre == PRE_MAX);

   // lap loses to start_stop and clear in the same cycle
   assign lap_act = lap && !start_stop && !clear;

   // ---------------- ripple carry ----------------
   assign cy[0] = unit_en;
   assign cy[1] = cy[0] && (cs0 >= 4'd9);
   assign cy[2] = cy[1] && (cs1 >= 4'd9);
   assign cy[3] = cy[2] && (s0  >= 4'd9);
   assign cy[4] = cy[3] && (s1  >= 4'd5);
   assign cy[5] = cy[4] && (m0  >= 4'd9);

   always_comb begin
      cs0_nx = cs0;
      cs1_nx = cs1;
      s0_nx  = s0;
      s1_nx  = s1;
      m0_nx  = m0;
      if (cy[0]) cs0_nx = bcd_inc(cs0, 4'd9);
      if (cy[1]) cs1_nx = bcd_inc(cs1, 4'd9);
      if (cy[2]) s0_nx  = bcd_inc(s0,  4'd9);
      if (cy[3]) s1_nx  = bcd_inc(s1,  4'd5);
      if (cy[4]) m0_nx  = bcd_inc(m0,  4'd9);
   end

   // ---------------- prescaler and live time ----------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pre  <= 8'd0;
         cs0  <= 4'd0;
         cs1  <= 4'd0;
         s0   <= 4'd0;
         s1   <= 4'd0;
         m0   <= 4'd0;
         wrap <= 1'b0;
      end else if (clear) begin
         pre  <= 8'd0;
         cs0  <= 4'd0;
         cs1  <= 4'd0;
         s0   <= 4'd0;
         s1   <= 4'd0;
         m0   <= 4'd0;
         wrap <= 1'b0;
      end else begin
         // prescaler value survives PAUSED untouched
         if (count_en) begin
            pre <= unit_en ? 8'd0 : pre + 8'd1;
         end
         cs0  <= cs0_nx;
         cs1  <= cs1_nx;
         s0   <= s0_nx;
         s1   <= s1_nx;
         m0   <= m0_nx;
         wrap <= cy[5];
      end
   end

   // ---------------- lap hold ----------------
   // Capture takes the live digits before this cycle's increment.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hold  <= 1'b0;
         h_cs0 <= 4'd0;
         h_cs1 <= 4'd0;
         h_s0  <= 4'd0;
         h_s1  <= 4'd0;
         h_m0  <= 4'd0;
      end else if (clear) begin
         hold  <= 1'b0;
         h_cs0 <= 4'd0;
         h_cs1 <= 4'd0;
         h_s0  <= 4'd0;
         h_s1  <= 4'd0;
         h_m0  <= 4'd0;
      end else if (lap_act) begin
         if (hold) begin
            hold <= 1'b0;
         end else if (state == RUN) begin
            hold  <= 1'b1;
            h_cs0 <= cs0;
            h_cs1 <= cs1;
            h_s0  <= s0;
            h_s1  <= s1;
            h_m0  <= m0;
         end
      end
   end

   // ---------------- outputs (register-only paths) ----------------
   assign running = (state == RUN);

   assign d_cs0 = hold ? h_cs0 : cs0;
   assign d_cs1 = hold ? h_cs1 : cs1;
   assign d_s0  = hold ? h_s0  : s0;
   assign d_s1  = hold ? h_s1  : s1;
   assign d_m0  = hold ? h_m0  : m0;

endmodule

// File: tb/tb_stopwatch_bcd.sv
// tb_stopwatch_bcd: scoreboard bench for stopwatch_bcd, three instances
// with TICKS_PER_UNIT = 2, 10 and 1, each driven independently.
module tb_stopwatch_bcd;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [2:0] tic_v = '0;
   logic [2:0] ss_v  = '0;
   logic [2:0] lap_v = '0;
   logic [2:0] clr_v = '0;

   logic [19:0] dig [3];
   logic [2:0]  run_o;
   logic [2:0]  hld_o;
   logic [2:0]  wrp_o;

   always #5 clk = ~clk;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      logic [3:0] cs0, cs1, s0, s1, m0;
      stopwatch_bcd #(
         .TICKS_PER_UNIT(g == 0 ? 2 : (g == 1 ? 10 : 1))
      ) dut (
         .clk       (clk),
         .rst       (rst),
         .tic       (tic_v[g]),
         .start_stop(ss_v[g]),
         .lap       (lap_v[g]),
         .clear     (clr_v[g]),
         .d_cs0     (cs0),
         .d_cs1     (cs1),
         .d_s0      (s0),
         .d_s1      (s1),
         .d_m0      (m0),
         .running   (run_o[g]),
         .hold      (hld_o[g]),
         .wrap      (wrp_o[g])
      );
      assign dig[g] = {m0, s1, s0, cs1, cs0};
   end

   typedef struct {
      int          idx;
      string       name;
      logic [19:0] d;
      logic        r;
      logic        h;
      logic        w;
   } exp_t;

   exp_t q[$];
   int   n_chk  = 0;
   int   n_pass = 0;
   event chk_ev;

   task automatic exp_push(input int i, input string nm,
                           input logic [19:0] d,
                           input logic r, input logic h,
                           input logic w);
      exp_t e;
      e.idx = i; e.name = nm; e.d = d;
      e.r = r; e.h = h; e.w = w;
      q.push_back(e);
   endtask

   task automatic cyc(input int i, input logic t, input logic s,
                      input logic l, input logic c);
      tic_v[i] = t; ss_v[i] = s; lap_v[i] = l; clr_v[i] = c;
      @(posedge clk);
      #1;
      tic_v[i] = 1'b0; ss_v[i] = 1'b0;
      lap_v[i] = 1'b0; clr_v[i] = 1'b0;
   endtask

   // monitor: compares everything queued, away from the active edge
   initial begin
      forever begin
         @(negedge clk or chk_ev);
         while (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            n_chk++;
            if (dig[e.idx] == e.d && run_o[e.idx] == e.r &&
                hld_o[e.idx] == e.h && wrp_o[e.idx] == e.w) begin
               n_pass++;
            end else begin
               $display("FAIL %s dut%0d: got %h run=%b hold=%b wrap=%b, want %h run=%b hold=%b wrap=%b",
                        e.name, e.idx, dig[e.idx], run_o[e.idx],
                        hld_o[e.idx], wrp_o[e.idx],
                        e.d, e.r, e.h, e.w);
            end
         end
      end
   end

   initial begin
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      for (int i = 0; i < 3; i++) exp_push(i, "reset", 20'h0, 0, 0, 0);
      @(posedge clk); #1;

      // basic count, TICKS_PER_UNIT=2
      cyc(0, 0, 1, 0, 0);
      exp_push(0, "start", 20'h0, 1, 0, 0);
      for (int k = 1; k <= 20; k++) begin
         cyc(0, 1, 0, 0, 0);
         if (k == 1)  exp_push(0, "half_unit", 20'h00000, 1, 0, 0);
         if (k == 2)  exp_push(0, "one_unit", 20'h00001, 1, 0, 0);
         if (k == 20) exp_push(0, "basic_10", 20'h00010, 1, 0, 0);
      end
      cyc(0, 0, 1, 0, 0);
      exp_push(0, "stop", 20'h00010, 0, 0, 0);
      for (int k = 0; k < 4; k++) cyc(0, 1, 0, 0, 0);
      exp_push(0, "paused_tics", 20'h00010, 0, 0, 0);

      // start+tic in IDLE, then sub-unit retention, TICKS_PER_UNIT=10
      cyc(1, 1, 1, 0, 0);
      exp_push(1, "ss_tic_idle", 20'h0, 1, 0, 0);
      for (int k = 0; k < 5; k++) cyc(1, 1, 0, 0, 0);
      cyc(1, 0, 1, 0, 0);
      exp_push(1, "pause5", 20'h0, 0, 0, 0);
      for (int k = 0; k < 3; k++) cyc(1, 1, 0, 0, 0);
      cyc(1, 0, 1, 0, 0);
      exp_push(1, "resume", 20'h0, 1, 0, 0);
      for (int k = 0; k < 4; k++) cyc(1, 1, 0, 0, 0);
      exp_push(1, "ninth_tic", 20'h0, 1, 0, 0);
      cyc(1, 1, 0, 0, 0);
      exp_push(1, "tenth_tic", 20'h00001, 1, 0, 0);

      // carry chain and wrap, TICKS_PER_UNIT=1
      cyc(2, 0, 1, 0, 0);
      for (int k = 1; k <= 59999; k++) begin
         cyc(2, 1, 0, 0, 0);
         if (k == 1)     exp_push(2, "first", 20'h00001, 1, 0, 0);
         if (k == 5999)  exp_push(2, "0_59_99", 20'h05999, 1, 0, 0);
         if (k == 6000)  exp_push(2, "1_00_00", 20'h10000, 1, 0, 0);
         if (k == 59999) exp_push(2, "9_59_99", 20'h95999, 1, 0, 0);
      end
      cyc(2, 1, 0, 0, 0);
      exp_push(2, "wrap", 20'h00000, 1, 0, 1);
      cyc(2, 0, 0, 0, 0);
      exp_push(2, "wrap_1cyc", 20'h00000, 1, 0, 0);
      cyc(2, 1, 0, 0, 0);
      exp_push(2, "after_wrap", 20'h00001, 1, 0, 0);
      cyc(2, 1, 1, 0, 0);
      exp_push(2, "ss_tic_run", 20'h00002, 0, 0, 0);
      cyc(2, 0, 0, 0, 1);
      exp_push(2, "clear", 20'h0, 0, 0, 0);

      // lap hold
      cyc(2, 0, 1, 0, 0);
      for (int k = 0; k < 123; k++) cyc(2, 1, 0, 0, 0);
      exp_push(2, "at_1_23", 20'h00123, 1, 0, 0);
      cyc(2, 1, 0, 1, 0);
      exp_push(2, "lap_tic", 20'h00123, 1, 1, 0);
      for (int k = 0; k < 49; k++) cyc(2, 1, 0, 0, 0);
      exp_push(2, "held", 20'h00123, 1, 1, 0);
      cyc(2, 0, 0, 1, 0);
      exp_push(2, "release", 20'h00173, 1, 0, 0);
      cyc(2, 0, 0, 1, 0);
      exp_push(2, "relap", 20'h00173, 1, 1, 0);
      cyc(2, 0, 1, 1, 0);
      exp_push(2, "ss_lap", 20'h00173, 0, 1, 0);
      cyc(2, 0, 0, 1, 0);
      exp_push(2, "lap_paused", 20'h00173, 0, 0, 0);
      cyc(2, 0, 1, 0, 0);
      cyc(2, 1, 0, 0, 0);
      exp_push(2, "resumed", 20'h00174, 1, 0, 0);
      cyc(2, 0, 0, 1, 0);
      cyc(2, 1, 0, 1, 1);
      exp_push(2, "clr_tic_lap", 20'h0, 0, 0, 0);
      cyc(2, 1, 0, 0, 0);
      exp_push(2, "idle_tic", 20'h0, 0, 0, 0);
      cyc(2, 0, 0, 1, 0);
      exp_push(2, "idle_lap", 20'h0, 0, 0, 0);

      // async reset mid-run with hold set
      cyc(0, 0, 0, 0, 1);
      cyc(0, 0, 1, 0, 0);
      for (int k = 0; k < 690; k++) cyc(0, 1, 0, 0, 0);
      exp_push(0, "at_3_45", 20'h00345, 1, 0, 0);
      cyc(0, 0, 0, 1, 0);
      for (int k = 0; k < 4; k++) cyc(0, 1, 0, 0, 0);
      exp_push(0, "held_3_45", 20'h00345, 1, 1, 0);
      @(negedge clk);
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      exp_push(0, "async_rst", 20'h0, 0, 0, 0);
      exp_push(2, "async_rst", 20'h0, 0, 0, 0);
      -> chk_ev;
      #1;
      @(posedge clk); #2;
      rst = 1'b0;
      @(posedge clk); #1;
      for (int k = 0; k < 6; k++) cyc(0, 1, 0, 0, 0);
      exp_push(0, "post_rst", 20'h0, 0, 0, 0);

      repeat (2) @(posedge clk);
      #1;
      if (q.size() != 0) begin
         $display("FAIL drain: %0d expectations left, want 0", q.size());
         n_chk = n_chk + q.size();
      end
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/stopwatch_bcd.md
# stopwatch_bcd

Stopwatch timekeeper that consumes the 1 ms `tic` strobe produced by the free-running counter timer (100 000-cycle period at 100 MHz) and accumulates elapsed time as BCD digits in the format M:SS.CC, 0:00.00 to 9:59.99. It sits directly downstream of the timer and upstream of the seven-segment display driver. Start/stop, lap-hold and clear commands arrive as single-cycle pulses from the debounced pushbutton logic.

## Interface
- `TICKS_PER_UNIT`, default 10: number of `tic` pulses per 0.01 s increment; legal range 1–255.
- `clk` input 1: system clock, all logic on rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `tic` input 1: single-cycle timebase strobe from the counter timer.
- `start_stop` input 1: single-cycle pulse, toggles run/pause.
- `lap` input 1: single-cycle pulse, toggles display hold.
- `clear` input 1: single-cycle pulse, returns to zero/idle.
- `d_cs0` output 4: displayed hundredths-of-second units, BCD 0–9.
- `d_cs1` output 4: displayed tenths of a second, BCD 0–9.
- `d_s0` output 4: displayed seconds units, BCD 0–9.
- `d_s1` output 4: displayed seconds tens, BCD 0–5.
- `d_m0` output 4: displayed minutes, BCD 0–9.
- `running` output 1: high while in RUN.
- `hold` output 1: high while the display is frozen (lap).
- `wrap` output 1: one-cycle pulse when time rolls 9:59.99 → 0:00.00.

## Operation
- FSM states: IDLE, RUN, PAUSED. Reset state is IDLE.
- IDLE: `start_stop` → RUN. `lap` is ignored.
- RUN: `start_stop` → PAUSED.
- PAUSED: `start_stop` → RUN.
- `clear` in any state → IDLE. It zeroes the live time, the prescaler and the held digits, and clears `hold`. `clear` has priority over all other inputs in the same cycle.
- `start_stop` and `lap` in the same cycle: `start_stop` is acted on and `lap` is dropped.
- Prescaler: 8-bit counter.
  - Advances only on `tic` while the state register is RUN.
  - On `tic` with prescaler = `TICKS_PER_UNIT`-1: prescaler → 0 and live time increments by one hundredth.
  - Prescaler value is retained through PAUSED, so no sub-unit time is lost.
- BCD increment: ripple carry, each digit independent.
  - cs0: 9 → 0, carries into cs1.
  - cs1: 9 → 0, carries into s0.
  - s0: 9 → 0, carries into s1.
  - s1: 5 → 0, carries into m0.
  - m0: 9 → 0, and `wrap` pulses. Counting continues after the wrap.
  - Digit values are never non-BCD.
- Lap hold:
  - In RUN with `hold`=0, `lap` copies the live time into the hold register and sets `hold`.
  - `lap` with `hold`=1, in RUN or PAUSED, clears `hold`.
  - The live time keeps counting while held.
- Display outputs show the hold register when `hold`=1, otherwise the live time.

## Timing
- Reset values: all digit outputs 0, `running`=0, `hold`=0, `wrap`=0, prescaler 0, state IDLE.
- All outputs are registered or derived directly from registers. No combinational path from any input to any output.
- A qualifying `tic` at edge k makes the new digits visible after edge k, i.e. one cycle of latency. `wrap` is high for exactly that one cycle.
- `tic` is sampled against the current state, before the transition:
  - A `tic` coincident with `start_stop` in IDLE or PAUSED is not counted.
  - A `tic` coincident with `start_stop` in RUN is counted.
- `running` rises or falls one cycle after the `start_stop` pulse.
- A `lap` capture coincident with a qualifying `tic` captures the pre-increment value.
- `clear` coincident with `tic`: the result is zero; the `tic` is discarded.
- Reset asserted mid-count returns all state and outputs to reset values immediately (asynchronous). Operation resumes from IDLE on the first edge after release.

## Test plan
- Basic count: reset, then `TICKS_PER_UNIT`=2, `start_stop`, 20 `tic` pulses → digits 0:00.10, `running`=1. Then `start_stop`, 4 `tic` pulses → digits unchanged at 0:00.10, `running`=0.
- Sub-unit retention: `TICKS_PER_UNIT`=10, run 5 `tic`, pause, resume, 5 `tic` → 0:00.01 appears exactly after the 10th counted `tic`.
- Carry and wrap: run from 0:00.00 with `TICKS_PER_UNIT`=1 for 59 999 `tic` → 9:59.99. One more `tic` → 0:00.00 with a single-cycle `wrap`. The 0:59.99 → 1:00.00 transition is checked on the way.
- Lap: run to 0:01.23, pulse `lap` → outputs frozen at 0:01.23 and `hold`=1 while live time advances 50 units. Pulse `lap` again → outputs show 0:01.73.
- Simultaneous events:
  - `start_stop`+`tic` in IDLE → count stays 0.
  - `clear`+`tic`+`lap` in RUN → IDLE, all zero, `hold`=0.
  - `start_stop`+`lap` in RUN → PAUSED, `hold` unchanged.
- Async reset mid-run at 0:03.45 with `hold`=1 → all outputs 0 within the same cycle, without waiting for a clock edge. After release, `tic` pulses without `start_stop` → outputs stay 0.
